// File: rtl/serial_mag_comp_if.sv
// Operand/result bundle for serial_mag_comp: start/ready handshake, operands and registered verdict.
interface serial_mag_comp_if #(
  parameter int W = 8
);
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         done_tick;
  logic         gt;
  logic         eq;
  logic         lt;

  modport master (
    output start, a, b,
    input  ready, done_tick, gt, eq, lt
  );

  modport slave (
    input  start, a, b,
    output ready, done_tick, gt, eq, lt
  );
endinterface

// File: rtl/serial_mag_comp.sv
// Unsigned W-bit magnitude comparator walking 2-bit digits MSB-first; start-to-done latency W/2+1 edges.
// ready is high only in IDLE; start in RUN/DONE is ignored, so the requester waits on ready.
module serial_mag_comp #(
  parameter int W = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  serial_mag_comp_if.slave bus
);

  localparam int ND = W / 2;
  localparam int CW = $clog2(ND) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [W-1:0]  r_sa;
  logic [W-1:0]  r_sb;
  logic [CW-1:0] r_n;
  logic          r_dgt;
  logic          r_dlt;
  logic          r_gt;
  logic          r_eq;
  logic          r_lt;

  logic          w_load;
  logic          w_step;
  logic          w_last;
  logic [1:0]    w_da;
  logic [1:0]    w_db;
  logic          w_dig_gt;
  logic          w_dig_lt;
  logic          w_undecided;
  logic          w_dgt_nxt;
  logic          w_dlt_nxt;

  // The single 2-bit greater-than cell; used in both argument orders to get lt.
  function automatic logic dig_gt(input logic [1:0] x, input logic [1:0] y);
    return (x[1] & ~y[1]) | (~(x[1] ^ y[1]) & x[0] & ~y[0]);
  endfunction

  assign w_da        = r_sa[W-1 -: 2];
  assign w_db        = r_sb[W-1 -: 2];
  assign w_dig_gt    = dig_gt(w_da, w_db);
  assign w_dig_lt    = dig_gt(w_db, w_da);
  assign w_undecided = ~(r_dgt | r_dlt);
  assign w_dgt_nxt   = r_dgt | (w_undecided & w_dig_gt);
  assign w_dlt_nxt   = r_dlt | (w_undecided & w_dig_lt);
  assign w_last      = (r_n == CW'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_step = 1'b1;
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sa  <= '0;
      r_sb  <= '0;
      r_n   <= '0;
      r_dgt <= 1'b0;
      r_dlt <= 1'b0;
    end else if (w_load) begin
      r_sa  <= bus.a;
      r_sb  <= bus.b;
      r_n   <= CW'(ND);
      r_dgt <= 1'b0;
      r_dlt <= 1'b0;
    end else if (w_step) begin
      r_sa  <= r_sa << 2;
      r_sb  <= r_sb << 2;
      r_n   <= r_n - CW'(1);
      r_dgt <= w_dgt_nxt;
      r_dlt <= w_dlt_nxt;
    end
  end

  // Verdict captured on the RUN->DONE edge so it already folds in the final digit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_gt <= 1'b0;
      r_eq <= 1'b0;
      r_lt <= 1'b0;
    end else if (w_step && w_last) begin
      r_gt <= w_dgt_nxt;
      r_lt <= w_dlt_nxt;
      r_eq <= ~(w_dgt_nxt | w_dlt_nxt);
    end
  end

  assign bus.ready     = (r_state == S_IDLE);
  assign bus.done_tick = (r_state == S_DONE);
  assign bus.gt        = r_gt;
  assign bus.eq        = r_eq;
  assign bus.lt        = r_lt;

endmodule
